// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: bundles the pipeline writeback request, the long-unit
// result handshake, the decode issue/hazard check and the register-file write port.
//   master : the surrounding core (drives requests, receives grants/hazard/write port)
//   slave  : the scheduler itself
interface rf_write_scheduler_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
);
    // pipeline writeback request
    logic                     iPipeValid;
    logic [ADDRESS_WIDTH-1:0] iPipeAddr;
    logic [DATA_WIDTH-1:0]    iPipeData;
    // long-latency unit result
    logic                     iLongValid;
    logic [ADDRESS_WIDTH-1:0] iLongAddr;
    logic [DATA_WIDTH-1:0]    iLongData;
    logic                     oLongReady;
    // decode issue and hazard check
    logic                     iIssueValid;
    logic [ADDRESS_WIDTH-1:0] iIssueRd;
    logic [ADDRESS_WIDTH-1:0] iCheckRs1;
    logic [ADDRESS_WIDTH-1:0] iCheckRs2;
    logic [ADDRESS_WIDTH-1:0] iCheckRd;
    logic                     oHazard;
    logic                     oStallPipe;
    // register file write port
    logic                     oWriteEn;
    logic [ADDRESS_WIDTH-1:0] oWriteAddress;
    logic [DATA_WIDTH-1:0]    oWriteData;

    modport master (
        output iPipeValid, iPipeAddr, iPipeData,
        output iLongValid, iLongAddr, iLongData,
        input  oLongReady,
        output iIssueValid, iIssueRd, iCheckRs1, iCheckRs2, iCheckRd,
        input  oHazard, oStallPipe,
        input  oWriteEn, oWriteAddress, oWriteData
    );

    modport slave (
        input  iPipeValid, iPipeAddr, iPipeData,
        input  iLongValid, iLongAddr, iLongData,
        output oLongReady,
        input  iIssueValid, iIssueRd, iCheckRs1, iCheckRs2, iCheckRd,
        output oHazard, oStallPipe,
        output oWriteEn, oWriteAddress, oWriteData
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: shares the register file's single write port between the
// in-order pipeline writeback and a FIFO of long-latency results, and keeps a
// pending-write scoreboard so decode can stall on RAW/WAW hazards.
//   iClk, iRst : clock, synchronous active-high reset
//   bus        : rf_write_scheduler_if.slave (pipe request, long handshake,
//                issue/hazard check, register file write port)
module rf_write_scheduler #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    rf_write_scheduler_if.slave  bus
);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STV_W    = $clog2(STARVE_LIMIT) + 1;
    localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic [NUM_REGS-1:0]      pending;
    logic [STV_W-1:0]         starve_cnt;
    logic                     stall_q;

    logic                     empty_c;
    logic                     full_c;
    logic                     pipe_win_c;
    logic                     pop_c;
    logic                     push_c;
    logic                     starve_inc_c;
    logic [ADDRESS_WIDTH-1:0] head_addr_c;
    logic                     wr_req_c;
    logic [ADDRESS_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0]    wr_data_c;
    logic [NUM_REGS-1:0]      pending_nxt_c;
    logic [STV_W-1:0]         starve_nxt_c;
    logic                     stall_nxt_c;

    // Arbitration: the pipeline wins unless it is being deferred for one cycle.
    always_comb begin
        empty_c      = (count == '0);
        full_c       = (count == CNT_W'(FIFO_DEPTH));
        pipe_win_c   = !stall_q && bus.iPipeValid;
        pop_c        = !pipe_win_c && !empty_c;
        push_c       = bus.iLongValid && !full_c && !iRst;
        starve_inc_c = pipe_win_c && !empty_c;
        head_addr_c  = fifo_addr[rd_ptr];
    end

    // Write port mux; x0 writes are dropped but still consume the request.
    always_comb begin
        wr_req_c  = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (pipe_win_c) begin
            wr_req_c  = 1'b1;
            wr_addr_c = bus.iPipeAddr;
            wr_data_c = bus.iPipeData;
        end else if (pop_c) begin
            wr_req_c  = 1'b1;
            wr_addr_c = head_addr_c;
            wr_data_c = fifo_data[rd_ptr];
        end
    end

    assign bus.oWriteEn      = wr_req_c && (wr_addr_c != '0) && !iRst;
    assign bus.oWriteAddress = wr_addr_c;
    assign bus.oWriteData    = wr_data_c;
    assign bus.oLongReady    = !full_c && !iRst;
    assign bus.oStallPipe    = stall_q;
    assign bus.oHazard       = pending[bus.iCheckRs1] | pending[bus.iCheckRs2]
                             | pending[bus.iCheckRd];

    // Scoreboard update: a same-cycle issue overrides the commit clear.
    always_comb begin
        pending_nxt_c = pending;
        if (pop_c) begin
            pending_nxt_c[head_addr_c] = 1'b0;
        end
        if (bus.iIssueValid && (bus.iIssueRd != '0)) begin
            pending_nxt_c[bus.iIssueRd] = 1'b1;
        end
        pending_nxt_c[0] = 1'b0;
    end

    // Starvation tracking: stall the pipeline on the STARVE_LIMIT-th lost cycle.
    always_comb begin
        starve_nxt_c = starve_cnt;
        if (empty_c || pop_c) begin
            starve_nxt_c = '0;
        end else if (starve_inc_c && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
            starve_nxt_c = starve_cnt + STV_W'(1);
        end
        stall_nxt_c = starve_inc_c && (starve_cnt == STV_W'(STARVE_LIMIT - 1));
    end

    // Control state.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            pending    <= pending_nxt_c;
            starve_cnt <= starve_nxt_c;
            stall_q    <= stall_nxt_c;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge iClk) begin
        if (push_c) begin
            fifo_addr[wr_ptr] <= bus.iLongAddr;
            fifo_data[wr_ptr] <= bus.iLongData;
        end
    end
endmodule
